// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the RNBIP-2 pipe stages and the hazard controller.
// The pipe drives stage status (master); the controller returns enables (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       op_s1;
    logic [7:0]       op_s2;
    logic             we_s3;
    logic [2:0]       wa_s3;
    logic             rd_s3;
    logic             pc_load_s3;
    logic             hold;
    logic             pc_en;
    logic             s1_en;
    logic             s2_en;
    logic             s1_flush;
    logic             s2_flush;
    logic             s3_bubble;
    logic             fwd_sel;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output op_s1, op_s2, we_s3, wa_s3, rd_s3, pc_load_s3, hold,
        input  pc_en, s1_en, s2_en, s1_flush, s2_flush, s3_bubble,
        input  fwd_sel, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  op_s1, op_s2, we_s3, wa_s3, rd_s3, pc_load_s3, hold,
        output pc_en, s1_en, s2_en, s1_flush, s2_flush, s3_bubble,
        output fwd_sel, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing/hazard controller for the 3-stage RNBIP-2 pipe.
// Optional macro PIPE_FWD_EN: resolve non-load RAW hazards by forwarding.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        HOLD  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             raw;
    logic             op_s1_unused;

    logic pc_en_o, s1_en_o, s2_en_o;
    logic s1_flush_o, s2_flush_o, s3_bubble_o, fwd_sel_o;

    // Stage-1 opcode is observed only, kept for a future pre-decode.
    assign op_s1_unused = ^bus.op_s1;

    function automatic logic reads_rn(input logic [7:0] op);
        logic grp_a, grp_b;
        grp_a = op[7:3] inside {5'b00011, 5'b00100, 5'b01000,
                                5'b01010, 5'b01100, 5'b01101};
        grp_b = op[7] && !op[3] && (op[7:4] != 4'hF);
        return grp_a || grp_b;
    endfunction

    assign raw = bus.we_s3 && (bus.wa_s3 == bus.op_s2[2:0])
                 && reads_rn(bus.op_s2);

    // Event resolution: reset > taken transfer > hold > RAW.
    always_comb begin
        pc_en_o     = 1'b1;
        s1_en_o     = 1'b1;
        s2_en_o     = 1'b1;
        s1_flush_o  = 1'b0;
        s2_flush_o  = 1'b0;
        s3_bubble_o = 1'b0;
        fwd_sel_o   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = RUN;
        if (rst) begin
            pc_en_o     = 1'b0;
            s1_en_o     = 1'b0;
            s2_en_o     = 1'b0;
            s1_flush_o  = 1'b1;
            s2_flush_o  = 1'b1;
            s3_bubble_o = 1'b1;
        end else if (bus.pc_load_s3) begin
            s1_flush_o = 1'b1;
            s2_flush_o = 1'b1;
            flush_inc  = 1'b1;
            state_d    = FLUSH;
        end else if (bus.hold) begin
            pc_en_o     = 1'b0;
            s1_en_o     = 1'b0;
            s2_en_o     = 1'b0;
            s3_bubble_o = 1'b1;
            state_d     = HOLD;
        end else begin
            unique case (state_q)
                // Stage 2 holds a NOP or the writer has retired: no RAW.
                FLUSH, STALL: state_d = RUN;
                RUN, HOLD: begin
                    if (raw) begin
`ifdef PIPE_FWD_EN
                        if (bus.rd_s3) begin
                            pc_en_o     = 1'b0;
                            s1_en_o     = 1'b0;
                            s2_en_o     = 1'b0;
                            s3_bubble_o = 1'b1;
                            stall_inc   = 1'b1;
                            state_d     = STALL;
                        end else begin
                            fwd_sel_o = 1'b1;
                        end
`else
                        pc_en_o     = 1'b0;
                        s1_en_o     = 1'b0;
                        s2_en_o     = 1'b0;
                        s3_bubble_o = 1'b1;
                        stall_inc   = 1'b1;
                        state_d     = STALL;
`endif
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_inc && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.pc_en     = pc_en_o;
    assign bus.s1_en     = s1_en_o;
    assign bus.s2_en     = s2_en_o;
    assign bus.s1_flush  = s1_flush_o;
    assign bus.s2_flush  = s2_flush_o;
    assign bus.s3_bubble = s3_bubble_o;
    assign bus.fwd_sel   = fwd_sel_o;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (both PIPE_FWD_EN builds).
// Expected per-cycle outputs are queued with the stimulus and compared at negedge.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_STL = 2'b01;
    localparam logic [1:0] S_FLS = 2'b10;
    localparam logic [1:0] S_HLD = 2'b11;

    // {pc_en,s1_en,s2_en,s1_flush,s2_flush,s3_bubble,fwd_sel}
    localparam logic [6:0] RUNO = 7'b111_000_0;
    localparam logic [6:0] STLO = 7'b000_001_0;
    localparam logic [6:0] FLO  = 7'b111_110_0;
    localparam logic [6:0] RSTO = 7'b000_111_0;
    localparam logic [6:0] FWDO = 7'b111_000_1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  sbus ();

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk),
        .rst(rst),
        .bus(sbus.slave)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] op2;
        logic       we;
        logic [2:0] wa;
        logic       rd;
        logic       pl;
        logic       hd;
        logic [1:0] st;
        logic [6:0] ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } step_t;

    step_t q[$];
    logic [5:0] sq[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [40:0] obs();
        return {bus.state, bus.pc_en, bus.s1_en, bus.s2_en,
                bus.s1_flush, bus.s2_flush, bus.s3_bubble,
                bus.fwd_sel, bus.stall_cnt, bus.flush_cnt};
    endfunction

    function automatic logic [40:0] expv(input step_t s);
        return {s.st, s.ctl, s.sc, s.fc};
    endfunction

    task automatic add(input string name, input logic r,
                       input logic [7:0] op2, input logic we,
                       input logic [2:0] wa, input logic rd,
                       input logic pl, input logic hd,
                       input logic [1:0] st, input logic [6:0] ctl,
                       input logic [15:0] sc, input logic [15:0] fc);
        step_t s;
        s.name = name; s.rst = r; s.op2 = op2; s.we = we;
        s.wa = wa; s.rd = rd; s.pl = pl; s.hd = hd;
        s.st = st; s.ctl = ctl; s.sc = sc; s.fc = fc;
        q.push_back(s);
    endtask

    task automatic drv(input step_t s);
        @(posedge clk);
        #1;
        rst            = s.rst;
        bus.op_s1      = s.op2 ^ 8'h5A;
        bus.op_s2      = s.op2;
        bus.we_s3      = s.we;
        bus.wa_s3      = s.wa;
        bus.rd_s3      = s.rd;
        bus.pc_load_s3 = s.pl;
        bus.hold       = s.hd;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.we_s3 = 1'b0; bus.pc_load_s3 = 1'b0; bus.hold = 1'b0;
        bus.rd_s3 = 1'b0;
        sbus.we_s3 = 1'b0; sbus.rd_s3 = 1'b0;
    endtask

    task automatic test_reset();
        step_t s;
        add("rst_c1", 1, 8'h81, 1, 1, 1, 1, 1, S_RUN, RSTO, 0, 0);
        add("rst_c2", 1, 8'h81, 1, 1, 1, 1, 1, S_RUN, RSTO, 0, 0);
        add("rst_rel", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            drv(s);
            @(negedge clk);
            checks++;
            if (obs() !== expv(s)) begin
                failures++;
                $display("FAIL reset/%s got=%h want=%h", s.name, obs(), expv(s));
            end
        end
    endtask

    task automatic test_alu_raw();
        step_t s;
        do_reset();
        add("alu_a", 0, 8'h81, 1, 1, 0, 0, 0, S_RUN,
            FWD ? FWDO : STLO, 0, 0);
        add("alu_b", 0, 8'h81, 1, 1, 0, 0, 0, FWD ? S_RUN : S_STL,
            FWD ? FWDO : RUNO, FWD ? 16'd0 : 16'd1, 0);
        add("alu_c", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO,
            FWD ? 16'd0 : 16'd1, 0);
        add("alu_wa", 0, 8'h81, 1, 3, 0, 0, 0, S_RUN, RUNO,
            FWD ? 16'd0 : 16'd1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            drv(s);
            @(negedge clk);
            checks++;
            if (obs() !== expv(s)) begin
                failures++;
                $display("FAIL alu_raw/%s got=%h want=%h", s.name, obs(), expv(s));
            end
        end
    endtask

    task automatic test_decode();
        step_t s;
        do_reset();
        add("nr_F1", 0, 8'hF1, 1, 1, 1, 0, 0, S_RUN, RUNO, 0, 0);
        add("nr_89", 0, 8'h89, 1, 1, 1, 0, 0, S_RUN, RUNO, 0, 0);
        add("nr_11", 0, 8'h11, 1, 1, 1, 0, 0, S_RUN, RUNO, 0, 0);
        add("nr_79", 0, 8'h79, 1, 1, 1, 0, 0, S_RUN, RUNO, 0, 0);
        add("nr_we0", 0, 8'h1A, 0, 2, 1, 0, 0, S_RUN, RUNO, 0, 0);
        add("rd_1A", 0, 8'h1A, 1, 2, 1, 0, 0, S_RUN, STLO, 0, 0);
        add("rd_1A_s", 0, 8'h00, 0, 0, 0, 0, 0, S_STL, RUNO, 1, 0);
        add("rd_E5", 0, 8'hE5, 1, 5, 1, 0, 0, S_RUN, STLO, 1, 0);
        add("rd_E5_s", 0, 8'h00, 0, 0, 0, 0, 0, S_STL, RUNO, 2, 0);
        add("rd_end", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 2, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            drv(s);
            @(negedge clk);
            checks++;
            if (obs() !== expv(s)) begin
                failures++;
                $display("FAIL decode/%s got=%h want=%h", s.name, obs(), expv(s));
            end
        end
    endtask

    task automatic test_load_use();
        step_t s;
        do_reset();
        add("ld_a", 0, 8'h62, 1, 2, 1, 0, 0, S_RUN, STLO, 0, 0);
        add("ld_b", 0, 8'h62, 1, 2, 1, 0, 0, S_STL, RUNO, 1, 0);
        add("ld_c", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            drv(s);
            @(negedge clk);
            checks++;
            if (obs() !== expv(s)) begin
                failures++;
                $display("FAIL load_use/%s got=%h want=%h", s.name, obs(), expv(s));
            end
        end
    endtask

    task automatic test_jump();
        step_t s;
        do_reset();
        add("jmp_a", 0, 8'h81, 1, 1, 1, 1, 0, S_RUN, FLO, 0, 0);
        add("jmp_b", 0, 8'h81, 1, 1, 1, 0, 0, S_FLS, RUNO, 0, 1);
        add("jmp_c", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 0, 1);
        add("jj_a", 0, 8'h00, 0, 0, 0, 1, 0, S_RUN, FLO, 0, 1);
        add("jj_b", 0, 8'h00, 0, 0, 0, 1, 0, S_FLS, FLO, 0, 2);
        add("jj_c", 0, 8'h00, 0, 0, 0, 0, 0, S_FLS, RUNO, 0, 3);
        add("jj_d", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 0, 3);
        while (q.size() > 0) begin
            s = q.pop_front();
            drv(s);
            @(negedge clk);
            checks++;
            if (obs() !== expv(s)) begin
                failures++;
                $display("FAIL jump/%s got=%h want=%h", s.name, obs(), expv(s));
            end
        end
    endtask

    task automatic test_hold();
        step_t s;
        do_reset();
        add("hd_1", 0, 8'h00, 0, 0, 0, 0, 1, S_RUN, STLO, 0, 0);
        add("hd_2", 0, 8'h00, 0, 0, 0, 0, 1, S_HLD, STLO, 0, 0);
        add("hd_3", 0, 8'h00, 0, 0, 0, 0, 1, S_HLD, STLO, 0, 0);
        add("hd_x", 0, 8'h00, 0, 0, 0, 0, 0, S_HLD, RUNO, 0, 0);
        add("hd_r", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 0, 0);
        add("hr_a", 0, 8'h62, 1, 2, 1, 0, 1, S_RUN, STLO, 0, 0);
        add("hr_b", 0, 8'h62, 1, 2, 1, 0, 0, S_HLD, STLO, 0, 0);
        add("hr_c", 0, 8'h00, 0, 0, 0, 0, 0, S_STL, RUNO, 1, 0);
        add("hr_d", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 1, 0);
        add("jh_a", 0, 8'h00, 0, 0, 0, 1, 1, S_RUN, FLO, 1, 0);
        add("jh_b", 0, 8'h00, 0, 0, 0, 0, 1, S_FLS, STLO, 1, 1);
        add("jh_c", 0, 8'h00, 0, 0, 0, 0, 0, S_HLD, RUNO, 1, 1);
        add("jh_d", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 1, 1);
        while (q.size() > 0) begin
            s = q.pop_front();
            drv(s);
            @(negedge clk);
            checks++;
            if (obs() !== expv(s)) begin
                failures++;
                $display("FAIL hold/%s got=%h want=%h", s.name, obs(), expv(s));
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s;
        do_reset();
        add("rm_a", 0, 8'h62, 1, 2, 1, 0, 0, S_RUN, STLO, 0, 0);
        add("rm_b", 1, 8'h62, 1, 2, 1, 0, 0, S_STL, RSTO, 1, 0);
        add("rm_c", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 0, 0);
        add("rm_d", 0, 8'h00, 0, 0, 0, 1, 0, S_RUN, FLO, 0, 0);
        add("rm_e", 1, 8'h00, 0, 0, 0, 0, 0, S_FLS, RSTO, 0, 1);
        add("rm_f", 0, 8'h00, 0, 0, 0, 0, 0, S_RUN, RUNO, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            drv(s);
            @(negedge clk);
            checks++;
            if (obs() !== expv(s)) begin
                failures++;
                $display("FAIL reset_mid/%s got=%h want=%h", s.name, obs(), expv(s));
            end
        end
    endtask

    task automatic test_saturation();
        logic [5:0] e;
        logic [5:0] o;
        int n;
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk);
            #1;
            rst          = 1'b0;
            sbus.op_s2   = 8'h62;
            sbus.wa_s3   = 3'd2;
            sbus.we_s3   = (i < 40);
            sbus.rd_s3   = (i < 40);
            n = (i + 1) / 2;
            if (n > 15) n = 15;
            sq.push_back({(i % 2 == 1) ? S_STL : S_RUN, 4'(n)});
            @(negedge clk);
            e = sq.pop_front();
            o = {sbus.state, sbus.stall_cnt};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sat/cyc%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.op_s1 = 8'h00; bus.op_s2 = 8'h00; bus.we_s3 = 1'b0;
        bus.wa_s3 = 3'd0; bus.rd_s3 = 1'b0; bus.pc_load_s3 = 1'b0;
        bus.hold = 1'b0;
        sbus.op_s1 = 8'h00; sbus.op_s2 = 8'h00; sbus.we_s3 = 1'b0;
        sbus.wa_s3 = 3'd0; sbus.rd_s3 = 1'b0; sbus.pc_load_s3 = 1'b0;
        sbus.hold = 1'b0;
        test_reset();
        test_alu_raw();
        test_decode();
        test_load_use();
        test_jump();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
